// File: rtl/nco_pkg.sv
// nco_pkg: shared types and constants for the NCO datapath.
//   SAMPLE_W     sine-table sample width
//   LERP_FRAC_W  interpolation fraction width
//   LERP_TAG_W   voice/channel tag width
//   sample_t     signed table sample
//   lerp_stage_t canonical layout of one interpolator pipeline stage at the
//                default widths; 'arith' carries the difference in S1, the
//                scaled product in S2 and the result in S3.
package nco_pkg;
  localparam int SAMPLE_W     = 12;
  localparam int LERP_FRAC_W  = 8;
  localparam int LERP_TAG_W   = 2;
  localparam int LERP_ARITH_W = SAMPLE_W + LERP_FRAC_W + 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic                           valid;
    logic [LERP_TAG_W-1:0]          tag;
    sample_t                        first;
    logic [LERP_FRAC_W-1:0]         frac;
    logic signed [LERP_ARITH_W-1:0] arith;
  } lerp_stage_t;
endpackage

// File: rtl/lerp_stage_reg.sv
// lerp_stage_reg: one valid/ready pipeline register slot.
//   clk, reset_n          clock, asynchronous active-low reset (valid only)
//   in_valid/in_ready     upstream handshake; in_ready = ~valid | out_ready
//   in_data               payload captured on an accepted transfer
//   out_valid/out_ready   downstream handshake
//   out_data              registered payload
// Only the valid bit is reset; the payload is qualified by it.
module lerp_stage_reg
  import nco_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);
  logic                 vld_q;
  logic [PAYLOAD_W-1:0] data_q;

  // Slot can take new data when empty or when its content leaves this edge.
  assign in_ready = ~vld_q | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
    end else if (in_ready) begin
      vld_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      data_q <= in_data;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
endmodule

// File: rtl/lerp_pipe.sv
// lerp_pipe: 3-stage handshaked signed linear interpolator.
//   out = first + ((second - first) * frac) >>> FRAC_BITS
// Build option: define LERP_ROUND_EN to add 2^(FRAC_BITS-1) before the shift
// (round half up); otherwise the shift floors toward -inf. Latency is 3 in
// both builds.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake
//   in_first, in_second          signed samples at table index n, n+1
//   in_frac                      unsigned fractional phase
//   in_tag                       channel id, passed through
//   out_valid/out_ready          output handshake
//   out_data, out_tag            interpolated sample and its channel id
//   busy                         any stage holds valid data
module lerp_pipe
  import nco_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int FRAC_BITS = LERP_FRAC_W,
  parameter int TAG_W     = LERP_TAG_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_first,
  input  logic signed [WIDTH-1:0] in_second,
  input  logic [FRAC_BITS-1:0]    in_frac,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);
  localparam int DIFF_W = WIDTH + 1;
  localparam int PROD_W = WIDTH + FRAC_BITS + 2;

  typedef struct packed {
    logic [TAG_W-1:0]          tag;
    logic signed [WIDTH-1:0]   first;
    logic [FRAC_BITS-1:0]      frac;
    logic signed [DIFF_W-1:0]  diff;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0]          tag;
    logic signed [WIDTH-1:0]   first;
    logic signed [PROD_W-1:0]  prod;
  } s2_t;

  typedef struct packed {
    logic [TAG_W-1:0]          tag;
    logic signed [WIDTH-1:0]   res;
  } s3_t;

  // Signed difference times the fraction taken as a non-negative number.
  // Both operands are widened to PROD_W first so the product is exact.
  function automatic logic signed [PROD_W-1:0] scale_frac(
    input logic signed [DIFF_W-1:0] d,
    input logic [FRAC_BITS-1:0]     f
  );
    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] f_ext;
    d_ext = PROD_W'(d);
    f_ext = PROD_W'($signed({1'b0, f}));
    return d_ext * f_ext;
  endfunction

  // The scaled step never exceeds the difference, so first + step lies
  // between first and second and fits WIDTH; modulo truncation is exact.
  function automatic logic signed [WIDTH-1:0] lerp_round(
    input logic signed [WIDTH-1:0]  first,
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] biased;
    logic signed [PROD_W-1:0] step;
`ifdef LERP_ROUND_EN
    biased = prod + $signed(PROD_W'(1) << (FRAC_BITS - 1));
`else
    biased = prod;
`endif
    step = biased >>> FRAC_BITS;
    return first + WIDTH'(step);
  endfunction

  s1_t  s1_d, s1_p0;
  s2_t  s2_d, s2_p1;
  s3_t  s3_d, s3_p2;
  logic vld_p0, vld_p1, vld_p2;
  logic rdy_p0, rdy_p1, rdy_p2;

  // ---- S1: capture operands and their difference
  always_comb begin
    s1_d.tag   = in_tag;
    s1_d.first = in_first;
    s1_d.frac  = in_frac;
    s1_d.diff  = DIFF_W'(in_second) - DIFF_W'(in_first);
  end

  lerp_stage_reg #(.PAYLOAD_W($bits(s1_t))) u_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (rdy_p0),
    .in_data  (s1_d),
    .out_valid(vld_p0),
    .out_ready(rdy_p1),
    .out_data (s1_p0)
  );

  // ---- S2: scale the difference by the fraction
  always_comb begin
    s2_d.tag   = s1_p0.tag;
    s2_d.first = s1_p0.first;
    s2_d.prod  = scale_frac(s1_p0.diff, s1_p0.frac);
  end

  lerp_stage_reg #(.PAYLOAD_W($bits(s2_t))) u_s2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (vld_p0),
    .in_ready (rdy_p1),
    .in_data  (s2_d),
    .out_valid(vld_p1),
    .out_ready(rdy_p2),
    .out_data (s2_p1)
  );

  // ---- S3: shift back and add to the base sample
  always_comb begin
    s3_d.tag = s2_p1.tag;
    s3_d.res = lerp_round(s2_p1.first, s2_p1.prod);
  end

  lerp_stage_reg #(.PAYLOAD_W($bits(s3_t))) u_s3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (vld_p1),
    .in_ready (rdy_p2),
    .in_data  (s3_d),
    .out_valid(vld_p2),
    .out_ready(out_ready),
    .out_data (s3_p2)
  );

  // ---- Output: payload registers are not reset, so qualify them by valid
  assign in_ready  = rdy_p0;
  assign out_valid = vld_p2;
  assign out_data  = vld_p2 ? s3_p2.res : '0;
  assign out_tag   = vld_p2 ? s3_p2.tag : '0;
  assign busy      = vld_p0 | vld_p1 | vld_p2;
endmodule

// File: tb/tb_lerp_pipe.sv
// tb_lerp_pipe: bench for lerp_pipe. Hand-computed vector table, handshake
// corner sequences, and randomized streams checked against an arithmetic
// reference model and an in-order scoreboard.
module tb_lerp_pipe;
  localparam int WIDTH     = 12;
  localparam int FRAC_BITS = 8;
  localparam int TAG_W     = 2;
`ifdef LERP_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_first = '0;
  logic signed [WIDTH-1:0] in_second = '0;
  logic [FRAC_BITS-1:0]    in_frac = '0;
  logic [TAG_W-1:0]        in_tag = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] out_data;
  logic [TAG_W-1:0]        out_tag;
  logic                    busy;

  always #5 clk = ~clk;

  lerp_pipe #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_first (in_first),
    .in_second(in_second),
    .in_frac  (in_frac),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  int checks = 0;
  int passes = 0;
  int pops   = 0;

  typedef struct {
    int data;
    int tag;
  } exp_t;
  exp_t exp_q[$];

  bit prev_hold = 1'b0;
  int prev_data = 0;
  int prev_tag  = 0;

  typedef struct {
    int first;
    int second;
    int frac;
    int tag;
    int exp_floor;
    int exp_round;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int floor_div(input int num, input int den);
    int q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q--;
    return q;
  endfunction

  // Interpolation from the arithmetic definition: first + floor(w*diff).
  function automatic int ref_lerp(input int f, input int s, input int fr);
    int num;
    num = (s - f) * fr;
    if (ROUND) num += 1 << (FRAC_BITS - 1);
    return f + floor_div(num, 1 << FRAC_BITS);
  endfunction

  // One clock: sample handshake before the edge, update scoreboard at it.
  // Called after inputs are driven (just after a negedge); returns at a negedge.
  task automatic step(output bit acc);
    bit   inf, outf;
    int   od, ot;
    exp_t e;
    #1;
    inf  = in_valid && in_ready;
    outf = out_valid && out_ready;
    od   = int'(out_data);
    ot   = int'(out_tag);
    if (prev_hold) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", od, prev_data);
      check("hold_tag", ot, prev_tag);
    end
    prev_hold = out_valid && !out_ready;
    prev_data = od;
    prev_tag  = ot;
    @(posedge clk);
    if (inf) begin
      e.data = ref_lerp(int'(in_first), int'(in_second), int'(in_frac));
      e.tag  = int'(in_tag);
      exp_q.push_back(e);
    end
    if (outf) begin
      check("out_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        check("stream_data", od, e.data);
        check("stream_tag", ot, e.tag);
      end
    end
    acc = inf;
    @(negedge clk);
  endtask

  task automatic stream(input int n, input int in_pct, input int out_pct,
                        input bit sweep, output int cycles);
    int sent;
    bit pending;
    bit acc;
    int limit;
    sent    = 0;
    pending = 1'b0;
    limit   = n * 30 + 200;
    cycles  = 0;
    while ((sent < n || exp_q.size() > 0) && cycles < limit) begin
      if (!pending) begin
        if (sent < n && $urandom_range(99) < in_pct) begin
          if (sweep) begin
            in_first  = -12'sd2048;
            in_second = 12'sd2047;
            in_frac   = FRAC_BITS'(sent);
          end else begin
            in_first  = WIDTH'($urandom);
            in_second = WIDTH'($urandom);
            in_frac   = FRAC_BITS'($urandom);
          end
          in_tag   = TAG_W'($urandom);
          in_valid = 1'b1;
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(99) < out_pct);
      step(acc);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    check("stream_complete", int'(sent == n && exp_q.size() == 0), 1);
  endtask

  task automatic set_pair(input int i);
    in_first  = WIDTH'(10 * i - 30);
    in_second = WIDTH'(-50 * i + 400);
    in_frac   = FRAC_BITS'(37 * i + 5);
    in_tag    = TAG_W'(i % 4);
  endtask

  task automatic check_vector(input vec_t v);
    int lat;
    in_first  = WIDTH'(v.first);
    in_second = WIDTH'(v.second);
    in_frac   = FRAC_BITS'(v.frac);
    in_tag    = TAG_W'(v.tag);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("vec_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("vec_latency", lat, 3);
    check("vec_data", int'(out_data), ROUND ? v.exp_round : v.exp_floor);
    check("vec_tag", int'(out_tag), v.tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  idx, c, cyc, stale, pops0;
    bit  acc;

    //             first  second frac tag floor round
    vecs[0] = '{   100,    200, 128,  1,   150,  150};
    vecs[1] = '{   200,    100,   1,  2,   199,  200};
    vecs[2] = '{ -2048,   2047, 255,  3,  2031, 2031};
    vecs[3] = '{ -2048,   2047,   0,  0, -2048, -2048};
    vecs[4] = '{     5,      5,  77,  1,     5,    5};
    vecs[5] = '{  2047,  -2048, 255,  2, -2033, -2032};
    vecs[6] = '{     0,      1, 128,  3,     0,    1};
    vecs[7] = '{  -100,   -300,  64,  0,  -150, -150};

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_tag", int'(out_tag), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", int'(in_ready), 1);
    check("rel_out_valid", int'(out_valid), 0);
    check("rel_busy", int'(busy), 0);

    // Hand-computed vectors with latency and tag echo
    for (int i = 0; i < 8; i++) check_vector(vecs[i]);

    // Full fraction sweep across the widest span
    stream(256, 100, 100, 1'b1, cyc);

    // Back-to-back throughput
    stream(200, 100, 100, 1'b0, cyc);
    check("throughput_cycles", int'(cyc <= 205), 1);

    // Stall: fill with out_ready low, then drain in order
    pops0     = pops;
    out_ready = 1'b0;
    idx       = 0;
    for (int k = 0; k < 6; k++) begin
      set_pair(idx);
      in_valid = 1'b1;
      step(acc);
      if (acc) idx++;
    end
    #1;
    check("stall_accepted", idx, 3);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_busy", int'(busy), 1);
    check("stall_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    c = 0;
    while ((idx < 5 || exp_q.size() > 0) && c < 20) begin
      if (idx < 5) begin
        set_pair(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step(acc);
      if (acc) idx++;
      c++;
    end
    in_valid = 1'b0;
    #1;
    check("stall_drained", int'(idx == 5 && exp_q.size() == 0), 1);
    check("stall_result_count", pops - pops0, 5);
    check("stall_busy_low", int'(busy), 0);

    // Random handshake traffic
    stream(1000, 60, 60, 1'b0, cyc);
    #1;
    check("random_busy_low", int'(busy), 0);

    // Reset with three samples in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_pair(k + 7);
      in_valid = 1'b1;
      step(acc);
    end
    in_valid = 1'b0;
    #1;
    check("flight_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    exp_q.delete();
    prev_hold = 1'b0;
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid) stale++;
      @(negedge clk);
    end
    check("stale_after_reset", stale, 0);
    check_vector(vecs[1]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lerp_pipe.md
Name: lerp_pipe

Overview:
- Pipelined, handshaked signed linear interpolator; the next generation of the NCO's combinational Lerp.
- Computes out = first + ((second - first) * frac) / 2^FRAC_BITS for signed sine-table samples.
- Sits between the phase-accumulator/LUT fetch stage and the DAC output formatter.
- Carries a channel tag so multiple NCO voices can be time-multiplexed through one instance.

Parameters:
- WIDTH, 12, signed sample width of first/second/out.
- FRAC_BITS, 8, interpolation fraction width; weight = frac / 2^FRAC_BITS, range [0, 1).
- TAG_W, 2, channel tag width passed through unchanged.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample pair valid.
- in_ready  out  1  block can accept input this cycle.
- in_first  in  WIDTH  signed sample at table index n.
- in_second  in  WIDTH  signed sample at table index n+1.
- in_frac  in  FRAC_BITS  unsigned fractional phase bits.
- in_tag  in  TAG_W  channel id.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  signed interpolated sample.
- out_tag  out  TAG_W  channel id of out_data.
- busy  out  1  any stage holds valid data.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0, out_data=0, out_tag=0, busy=0; in_ready=1 once reset_n is high.
- Handshake: a transfer occurs when valid && ready on the same edge. Valid and payload hold stable until accepted. No combinational path from in_valid to out_valid.
- Pipeline has 3 stages, with latency 3 cycles from input acceptance to out_valid when out_ready=1. Throughput is 1 per cycle.
  - S1: register first, tag, frac; diff = second - first, signed WIDTH+1 bits.
  - S2: prod = diff * $signed({1'b0, frac}), signed WIDTH+FRAC_BITS+2 bits; first, tag forwarded.
  - S3: out = first + (prod >>> FRAC_BITS), truncated to WIDTH. The result always lies between first and second inclusive, so no overflow or saturation logic is required.
- Per-stage ready: ready_k = ~valid_k | ready_{k+1}; ready_4 = out_ready; in_ready = ready_1 (combinational from out_ready through stage valids).
- Stall: with out_ready=0, stages fill in order. in_ready falls once all 3 are full. No data is lost or duplicated, and order is preserved.
- Simultaneous accept at input and output when full: pipeline shifts and one new pair enters.
- frac=0 gives out == first exactly. first == second gives out == first for any frac.
- busy = OR of stage valids.
- reset_n low mid-operation: all in-flight data is discarded immediately (async). No output for those samples after release.

Optional Feature:
- LERP_ROUND_EN defined: S3 adds 2^(FRAC_BITS-1) to prod before the arithmetic shift (round half up). The result still lies within [min(first,second), max(first,second)].
- Undefined: plain arithmetic shift (floor toward -inf). Latency is identical in both builds.

Decomposition:
- Package nco_pkg holds:
  - SAMPLE_W=12 and LERP_FRAC_W=8 constants;
  - typedef logic signed [SAMPLE_W-1:0] sample_t;
  - a packed struct lerp_stage_t {valid, tag, first, frac/diff/prod field}.
- One sub-module, lerp_stage_reg: a generic valid/ready pipeline register parametrised on payload width, instantiated 3 times. The arithmetic stays in lerp_pipe.

Test Plan:
- first=100, second=200, frac=128, out_ready=1 -> out_data=150 exactly 3 cycles after accept, tag echoed.
- first=200, second=100, frac=1 -> out_data=199 without LERP_ROUND_EN; 200 with it.
- first=-2048, second=2047, frac=255 -> 2031; frac=0 -> -2048; sweep frac 0..255 and check against a bench reference model in both builds.
- out_ready=0, offer 5 back-to-back pairs (tags 0..3,0) -> in_ready low after 3 accepted. Release out_ready -> 5 results in order, none lost, busy falls after last.
- Random in_valid/out_ready toggling over 1000 transfers -> scoreboard order and values match; out payload stable while out_valid && !out_ready.
- Assert reset_n low with 3 samples in flight -> out_valid=0 and busy=0 immediately; no stale outputs after release.
